// File: rtl/router_pkg.sv
// Shared mesh-router definitions: global sizing macros, packet field offsets,
// router port indices and small packet field helpers.

`ifndef PL
`define PL 16
`endif
`ifndef CS
`define CS 3
`endif
`ifndef REN
`define REN 5
`endif

package router_pkg;

    // Packet layout, bit 0 first (packets are declared [0:`PL-1])
    localparam int VALID_BIT   = 0;
    localparam int X_LSB       = 1;
    localparam int Y_LSB       = `CS + 1;
    localparam int PAYLOAD_LSB = 2 * `CS + 1;

    // Router port indices
    localparam int CORE  = 0;
    localparam int NORTH = 1;
    localparam int EAST  = 2;
    localparam int SOUTH = 3;
    localparam int WEST  = 4;

    typedef enum logic [2:0] {
        PORT_CORE  = 3'd0,
        PORT_NORTH = 3'd1,
        PORT_EAST  = 3'd2,
        PORT_SOUTH = 3'd3,
        PORT_WEST  = 3'd4
    } port_e;

    // Valid flag of a packet
    function automatic logic pkt_valid(input logic [0:`PL-1] p);
        return p[VALID_BIT];
    endfunction

    // Destination X field of a packet
    function automatic logic [0:`CS-1] pkt_dest_x(input logic [0:`PL-1] p);
        return p[X_LSB +: `CS];
    endfunction

    // Destination Y field of a packet
    function automatic logic [0:`CS-1] pkt_dest_y(input logic [0:`PL-1] p);
        return p[Y_LSB +: `CS];
    endfunction

endpackage

// File: rtl/packet_queue.sv
// Per-port packet FIFO of the mesh router. Pointer/count control and the
// storage array live in this one module; the router instantiates `REN copies.
//
// Handshake: a packet is accepted at a rising edge when packet_in[VALID_BIT]
// is high and availability_out was high before that edge (count < DEPTH);
// the head is consumed at a rising edge when pop is high and the queue is not
// empty. availability_out is the "ready" and comes only from registered count,
// so a same-cycle pop never frees a slot early. Invalid pushes (full) and
// invalid pops (empty) are dropped and recorded in sticky error flags.

`ifndef PL
`define PL 16
`endif
`ifndef CS
`define CS 3
`endif
`ifndef REN
`define REN 5
`endif

module packet_queue
    import router_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [0:`PL-1]  packet_in,
    output logic            availability_out,
    output logic [0:`PL-1]  packet_out,
    input  logic            pop,
    output logic [CW-1:0]   count,
    output logic            overflow,
    output logic            underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [0:`PL-1] mem [DEPTH];
    logic [AW-1:0]  rd;
    logic [AW-1:0]  wr;

    logic in_valid;
    logic full;
    logic empty;
    logic push;
    logic pop_ok;

    // Accept/consume decisions, all based on the pre-edge occupancy
    always_comb begin
        in_valid = pkt_valid(packet_in);
        full     = (count == CW'(DEPTH));
        empty    = (count == '0);
        push     = in_valid && !full;
        pop_ok   = pop && !empty;
    end

    // Storage write; contents are not cleared by reset, only the pointers are
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr] <= packet_in;
        end
    end

    // Pointers, occupancy and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            rd        <= '0;
            wr        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                wr <= wr + AW'(1);
            end
            if (pop_ok) begin
                rd <= rd + AW'(1);
            end
            case ({push, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (in_valid && full) begin
                overflow <= 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Head packet is forced to zero when empty so downstream sees valid = 0
    always_comb begin
        availability_out = !full;
        packet_out       = empty ? '0 : mem[rd];
    end

endmodule

// File: tb/tb_packet_queue.sv
// Directed bench for packet_queue with a scoreboard of expected head packets.

`ifndef PL
`define PL 16
`endif
`ifndef CS
`define CS 3
`endif
`ifndef REN
`define REN 5
`endif

module tb_packet_queue;
    import router_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [0:`PL-1] packet_in = '0;
    logic           pop       = 1'b0;
    logic           availability_out;
    logic [0:`PL-1] packet_out;
    logic [CW-1:0]  count;
    logic           overflow;
    logic           underflow;

    packet_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .packet_in        (packet_in),
        .availability_out (availability_out),
        .packet_out       (packet_out),
        .pop              (pop),
        .count            (count),
        .overflow         (overflow),
        .underflow        (underflow)
    );

    // ---------------- scoreboard ----------------
    logic [`PL-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [0:`PL-1] mk(input logic [15:0] v);
        logic [0:`PL-1] p;
        p = v;
        p[VALID_BIT] = 1'b1;
        return p;
    endfunction

    // Drive a packet for one cycle and record it as expected output
    task automatic push_one(input logic [0:`PL-1] p);
        packet_in = p;
        exp_q.push_back(p);
        step();
        packet_in = '0;
    endtask

    // Pop once, comparing the head against the scoreboard before the edge
    task automatic pop_one(input string tag);
        logic [`PL-1:0] e;
        e = exp_q.pop_front();
        check(tag, packet_out, e);
        pop = 1'b1;
        step();
        pop = 1'b0;
    endtask

    task automatic check_status(input string tag, input int c, input logic ovf, input logic udf);
        check({tag, "_count"}, 16'(count), 16'(c));
        check({tag, "_ovf"},   16'(overflow), 16'(ovf));
        check({tag, "_udf"},   16'(underflow), 16'(udf));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [0:`PL-1] p;
        logic [`PL-1:0] e;

        // Reset held for 2 cycles with a valid packet on the input
        rst = 1'b1;
        packet_in = mk(16'h00F0);
        step();
        step();
        check_status("reset", 0, 1'b0, 1'b0);
        check("reset_out", packet_out, 16'h0);
        check("reset_avail", 16'(availability_out), 16'h1);
        rst = 1'b0;
        packet_in = '0;
        step();
        check("reset_no_push", 16'(count), 16'h0);

        // Fill: A1..A4, first one visible after one edge
        push_one(mk(16'h00A1));
        check("latency_head", packet_out, mk(16'h00A1));
        check("fill_avail_1", 16'(availability_out), 16'h1);
        push_one(mk(16'h00A2));
        push_one(mk(16'h00A3));
        push_one(mk(16'h00A4));
        check("full_count", 16'(count), 16'h4);
        check("full_avail", 16'(availability_out), 16'h0);

        // Overflow: A5 arrives while full and is dropped
        packet_in = mk(16'h00A5);
        step();
        packet_in = '0;
        check_status("overflow", 4, 1'b1, 1'b0);
        check("overflow_head", packet_out, mk(16'h00A1));

        // Drain A1..A4 in order, then the head reads zero (A5 never emerges)
        for (int i = 0; i < 4; i++) pop_one("drain");
        check("drain_empty_out", packet_out, 16'h0);
        check_status("drain", 0, 1'b1, 1'b0);
        check("drain_avail", 16'(availability_out), 16'h1);

        // Clear sticky flags
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_status("flags_cleared", 0, 1'b0, 1'b0);

        // Simultaneous push/pop at count 2 for 10 cycles across pointer wrap
        push_one(mk(16'($urandom_range(0, 16'hFFFF))));
        push_one(mk(16'($urandom_range(0, 16'hFFFF))));
        for (int i = 0; i < 10; i++) begin
            p = mk(16'($urandom_range(0, 16'hFFFF)));
            e = exp_q.pop_front();
            check("stream_head", packet_out, e);
            exp_q.push_back(p);
            packet_in = p;
            pop = 1'b1;
            step();
            check("stream_count", 16'(count), 16'h2);
        end
        packet_in = '0;
        pop = 1'b0;
        check_status("stream", 2, 1'b0, 1'b0);
        pop_one("stream_tail");
        pop_one("stream_tail");
        check("stream_empty_out", packet_out, 16'h0);

        // Pop while empty
        pop = 1'b1;
        step();
        pop = 1'b0;
        check_status("empty_pop", 0, 1'b0, 1'b1);

        // Push and pop together while empty: push lands, pop ignored
        rst = 1'b1;
        step();
        rst = 1'b0;
        packet_in = mk(16'h00C1);
        exp_q.push_back(mk(16'h00C1));
        pop = 1'b1;
        step();
        packet_in = '0;
        pop = 1'b0;
        check_status("empty_pushpop", 1, 1'b0, 1'b1);
        pop_one("empty_pushpop_head");
        check("empty_pushpop_drained", 16'(count), 16'h0);

        // Reset mid-operation with count 3; push/pop in the reset cycle ignored
        push_one(mk(16'h00D1));
        push_one(mk(16'h00D2));
        push_one(mk(16'h00D3));
        check("mid_count", 16'(count), 16'h3);
        rst = 1'b1;
        packet_in = mk(16'h00DF);
        pop = 1'b1;
        step();
        rst = 1'b0;
        packet_in = '0;
        pop = 1'b0;
        exp_q.delete();
        check("mid_rst_count", 16'(count), 16'h0);
        check("mid_rst_out", packet_out, 16'h0);
        push_one(mk(16'h00E1));
        check("post_rst_count", 16'(count), 16'h1);
        pop_one("post_rst_head");
        check("post_rst_empty", packet_out, 16'h0);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
